seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Sequence-detector controller: loads a length byte plus a 4-byte pattern,
// runs the detector after a one-cycle clear and a warm-up period, and counts
// matches toward a target. Outputs are decoded from state. Optional RUN
// timeout is enabled by defining SEQ_CTRL_TIMEOUT_EN.
module seq_det_ctrl #(
  parameter int CNT_W     = 8,
  parameter int TO_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             abort,
  input  logic             match_in,
  output logic             det_clr,
  output logic             det_en,
  output logic [31:0]      pattern,
  output logic [4:0]       seq_len,
  input  logic [CNT_W-1:0] hit_target,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_CLEAR = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Reject nonsensical parameterisations at elaboration time.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_det_ctrl: CNT_W must be at least 1");
  end
  if (TO_CYCLES < 1) begin : g_bad_to_cycles
    $error("seq_det_ctrl: TO_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [31:0]      pattern_q, pattern_d;
  logic [4:0]       seq_len_q, seq_len_d;
  logic [1:0]       idx_q, idx_d;
  // Warm-up counter must reach seq_len+1 (up to 32), hence 6 bits.
  logic [5:0]       wu_q, wu_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cfg_acc;
  logic             warm;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             to_expire;

  assign cfg_acc = cfg_valid && cfg_ready;

  // The detector's shift register is not fully primed for the first
  // seq_len+1 RUN cycles, so its match pulses are meaningless then.
  assign warm = (wu_q <= {1'b0, seq_len_q});

  // Saturating increment of the match counter.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // A target of zero means "count forever"; only a real target can finish.
  assign hit = match_in && (hit_target != '0) && (cnt_inc == hit_target);

  // Output decode depends on state only, so no input-to-output paths.
  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_CLEAR) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign det_clr   = (state_q == S_CLEAR);
  assign det_en    = (state_q == S_RUN);
  assign pattern   = pattern_q;
  assign seq_len   = seq_len_q;
  assign match_cnt = cnt_q;

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [TO_W-1:0] to_q, to_d;
  logic            timeout_q, timeout_d;
  logic            run_post;

  // Post-warm-up RUN cycle that is not being cancelled.
  assign run_post  = (state_q == S_RUN) && !abort && !warm;
  assign to_expire = run_post && (to_q == TO_W'(TO_CYCLES - 1));
  assign timeout   = timeout_q;

  // Timeout counter and flag; a target hit in the expiring cycle wins.
  always_comb begin
    to_d      = to_q;
    timeout_d = timeout_q;
    if (state_q == S_CLEAR) begin
      to_d      = '0;
      timeout_d = 1'b0;
    end else if ((state_q == S_DONE) && (abort || start)) begin
      timeout_d = 1'b0;
    end else if (run_post) begin
      to_d = to_q + TO_W'(1);
      if (to_expire && !hit) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_q      <= to_d;
      timeout_q <= timeout_d;
    end
  end
`else
  // No timeout: RUN is bounded only by the target or an abort.
  assign to_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Next-state and datapath updates; abort from any busy/holding state wins.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    seq_len_d = seq_len_q;
    idx_d     = idx_q;
    wu_d      = wu_q;
    cnt_d     = cnt_q;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_acc) begin
            seq_len_d = cfg_data[4:0];
            idx_d     = 2'd0;
            state_d   = S_LOAD;
          end
        end
        S_LOAD: begin
          // Pattern bytes arrive LSB first; gaps in cfg_valid just stall.
          if (cfg_acc) begin
            pattern_d[{idx_q, 3'b000} +: 8] = cfg_data;
            if (idx_q == 2'd3) begin
              state_d = S_READY;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        S_READY: begin
          // A zero-length pattern can never match, so refuse to run it.
          if (start && (seq_len_q != 5'd0)) begin
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt_d   = '0;
          wu_d    = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (warm) begin
            wu_d = wu_q + 6'd1;
          end else begin
            if (match_in) begin
              cnt_d = cnt_inc;
            end
            if (hit || to_expire) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_CLEAR;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      seq_len_q <= '0;
      idx_q     <= '0;
      wu_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      seq_len_q <= seq_len_d;
      idx_q     <= idx_d;
      wu_q      <= wu_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: a vector table walks load, run, rerun, abort and
// zero-length cases; hand sequences cover reset mid-load, counter saturation,
// the RUN timeout (both builds) and reset mid-run.
module tb_seq_det_ctrl;

  localparam int CNT_W = 8;
  localparam int ST_I = 0, ST_L = 1, ST_R = 2, ST_C = 3, ST_U = 4, ST_D = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic [7:0]       cfg_data;
  logic             cfg_ready;
  logic             start;
  logic             abort;
  logic             match_in;
  logic             det_clr;
  logic             det_en;
  logic [31:0]      pattern;
  logic [4:0]       seq_len;
  logic [CNT_W-1:0] hit_target;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic             timeout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cv;
    logic [7:0]  cd;
    logic        st;
    logic        ab;
    logic        mi;
    int          est;
    logic [7:0]  cnt;
    logic [4:0]  len;
    logic [31:0] pat;
  } vec_t;

  vec_t vq[$];

  seq_det_ctrl #(.CNT_W(CNT_W), .TO_CYCLES(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .start      (start),
    .abort      (abort),
    .match_in   (match_in),
    .det_clr    (det_clr),
    .det_en     (det_en),
    .pattern    (pattern),
    .seq_len    (seq_len),
    .hit_target (hit_target),
    .match_cnt  (match_cnt),
    .done       (done),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic cv, input logic [7:0] cd, input logic st,
                              input logic ab, input logic mi, input int est,
                              input logic [7:0] cnt, input logic [4:0] len,
                              input logic [31:0] pat);
    vec_t r;
    r.cv = cv; r.cd = cd; r.st = st; r.ab = ab; r.mi = mi;
    r.est = est; r.cnt = cnt; r.len = len; r.pat = pat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected output flags for a given controller state.
  task automatic chk_state(input string tag, input int est);
    chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'(est == ST_I || est == ST_L));
    chk({tag, " busy"},      32'(busy),      32'(est == ST_L || est == ST_C || est == ST_U));
    chk({tag, " done"},      32'(done),      32'(est == ST_D));
    chk({tag, " det_en"},    32'(det_en),    32'(est == ST_U));
    chk({tag, " det_clr"},   32'(det_clr),   32'(est == ST_C));
  endtask

  task automatic chk_reset(input string tag);
    chk_state(tag, ST_I);
    chk({tag, " pattern"},   pattern,          32'h0);
    chk({tag, " seq_len"},   32'(seq_len),     32'h0);
    chk({tag, " match_cnt"}, 32'(match_cnt),   32'h0);
    chk({tag, " timeout"},   32'(timeout),     32'h0);
  endtask

  task automatic drive(input logic cv, input logic [7:0] cd, input logic st,
                       input logic ab, input logic mi);
    cfg_valid = cv; cfg_data = cd; start = st; abort = ab; match_in = mi;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    drive(1'b1, b0, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b1, b1, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b1, b2, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b1, b3, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b1, b4, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // cv cd st ab mi | state cnt len pattern (after the clock edge)
    vq.push_back(mk(1, 8'h04, 0, 0, 0, ST_L, 0, 4, 32'h00000000));
    vq.push_back(mk(1, 8'hAA, 0, 0, 0, ST_L, 0, 4, 32'h000000AA));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_L, 0, 4, 32'h000000AA));
    vq.push_back(mk(1, 8'hBB, 0, 0, 0, ST_L, 0, 4, 32'h0000BBAA));
    vq.push_back(mk(1, 8'hCC, 0, 0, 0, ST_L, 0, 4, 32'h00CCBBAA));
    vq.push_back(mk(1, 8'hDD, 0, 0, 0, ST_R, 0, 4, 32'hDDCCBBAA));
    vq.push_back(mk(1, 8'h55, 1, 0, 0, ST_C, 0, 4, 32'hDDCCBBAA));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA)); // run cyc 0
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 1
    vq.push_back(mk(0, 8'h00, 0, 0, 1, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 2 ignored
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 3
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 4
    vq.push_back(mk(0, 8'h00, 0, 0, 1, ST_U, 1, 4, 32'hDDCCBBAA)); // cyc 5
    vq.push_back(mk(0, 8'h00, 0, 0, 1, ST_U, 2, 4, 32'hDDCCBBAA)); // cyc 6
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 2, 4, 32'hDDCCBBAA)); // cyc 7
    vq.push_back(mk(0, 8'h00, 0, 0, 1, ST_D, 3, 4, 32'hDDCCBBAA)); // cyc 8 hit
    vq.push_back(mk(0, 8'h00, 0, 0, 1, ST_D, 3, 4, 32'hDDCCBBAA));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, ST_C, 3, 4, 32'hDDCCBBAA)); // rerun
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 0
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 1
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 2
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 3
    vq.push_back(mk(0, 8'h00, 0, 0, 1, ST_U, 0, 4, 32'hDDCCBBAA)); // cyc 4 last warm-up
    vq.push_back(mk(0, 8'h00, 0, 0, 1, ST_U, 1, 4, 32'hDDCCBBAA)); // cyc 5
    vq.push_back(mk(0, 8'h00, 1, 1, 1, ST_I, 1, 4, 32'hDDCCBBAA)); // abort wins
    vq.push_back(mk(0, 8'h00, 0, 0, 0, ST_I, 1, 4, 32'hDDCCBBAA));
    vq.push_back(mk(1, 8'h00, 0, 0, 0, ST_L, 1, 0, 32'hDDCCBBAA)); // zero length
    vq.push_back(mk(1, 8'h11, 0, 0, 0, ST_L, 1, 0, 32'hDDCCBB11));
    vq.push_back(mk(1, 8'h22, 0, 0, 0, ST_L, 1, 0, 32'hDDCC2211));
    vq.push_back(mk(1, 8'h33, 0, 0, 0, ST_L, 1, 0, 32'hDD332211));
    vq.push_back(mk(1, 8'h44, 0, 0, 0, ST_R, 1, 0, 32'h44332211));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, ST_R, 1, 0, 32'h44332211)); // start ignored
    vq.push_back(mk(0, 8'h00, 1, 0, 0, ST_R, 1, 0, 32'h44332211));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, ST_I, 1, 0, 32'h44332211));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, ST_I, 1, 0, 32'h44332211)); // abort in IDLE

    rst = 1'b1;
    hit_target = 8'd3;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    chk_reset("reset");
    tick;
    rst = 1'b0;

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      drive(vq[i].cv, vq[i].cd, vq[i].st, vq[i].ab, vq[i].mi);
      tick;
      chk_state(tag, vq[i].est);
      chk({tag, " match_cnt"}, 32'(match_cnt), 32'(vq[i].cnt));
      chk({tag, " seq_len"},   32'(seq_len),   32'(vq[i].len));
      chk({tag, " pattern"},   pattern,        vq[i].pat);
      chk({tag, " timeout"},   32'(timeout),   32'h0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset mid-LOAD after two bytes, then a fresh load.
    drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midload pattern", pattern, 32'h443322AA);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("midload rst");
    tick;
    rst = 1'b0;
    load5(8'h03, 8'h01, 8'h02, 8'h03, 8'h04);
    chk_state("reload", ST_R);
    chk("reload pattern", pattern, 32'h04030201);
    chk("reload seq_len", 32'(seq_len), 32'd3);

    // Target 0 never finishes; counter saturates (or times out if enabled).
    hit_target = 8'd0;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick;
    match_in = 1'b1;
    for (int k = 0; k < 300; k++) tick;
    match_in = 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
    chk_state("sat", ST_D);
    chk("sat match_cnt", 32'(match_cnt), 32'd20);
    chk("sat timeout", 32'(timeout), 32'd1);
`else
    chk_state("sat", ST_U);
    chk("sat match_cnt", 32'(match_cnt), 32'd255);
    chk("sat timeout", 32'(timeout), 32'd0);
`endif
    abort = 1'b1; tick; abort = 1'b0;
    chk_state("sat abort", ST_I);
    chk("sat abort timeout", 32'(timeout), 32'd0);
`ifdef SEQ_CTRL_TIMEOUT_EN
    chk("sat abort cnt", 32'(match_cnt), 32'd20);
`else
    chk("sat abort cnt", 32'(match_cnt), 32'd255);
`endif

    // Timeout run: seq_len 3 gives 4 warm-up cycles, then 20 counted cycles.
    load5(8'h03, 8'h01, 8'h02, 8'h03, 8'h04);
    hit_target = 8'd5;
    start = 1'b1; tick; start = 1'b0;
    chk_state("to clear", ST_C);
    tick;
    chk_state("to run", ST_U);
`ifdef SEQ_CTRL_TIMEOUT_EN
    for (int k = 0; k < 23; k++) tick;
    chk_state("to pre", ST_U);
    chk("to pre timeout", 32'(timeout), 32'd0);
    tick;
    chk_state("to hit", ST_D);
    chk("to hit timeout", 32'(timeout), 32'd1);
    start = 1'b1; tick; start = 1'b0;
    chk_state("to rerun", ST_C);
    chk("to rerun timeout", 32'(timeout), 32'd0);
    tick;
`else
    for (int k = 0; k < 100; k++) tick;
    chk_state("to 100", ST_U);
    chk("to 100 timeout", 32'(timeout), 32'd0);
`endif

    // Reset in the middle of a run discards it immediately.
    chk_state("prerst run", ST_U);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("midrun rst");
    tick;
    rst = 1'b0;
    tick;
    chk_reset("post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
